// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, datapath select codes
// and the packed control-word bundle driven to the datapath.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEX   = 4'd6,
      S_RTWB   = 4'd7,
      S_BEQ    = 4'd8,
      S_IEX    = 4'd9,
      S_IWB    = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_AND   = 2'b11;

   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
   } ctrl_t;

endpackage

// File: rtl/mc_output_decoder.sv
// Combinational state-to-control decode; zero latency. The only mem_ready dependence is the
// FETCH load strobes and the MEMWR retire pulse, so a stalled access keeps its request held.
module mc_output_decoder
   import mc_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] opcode_q,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_source = PCSRC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH2;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         // A store retires in the cycle its write is accepted.
         S_MEMWR: begin
            ctrl.mem_write  = 1'b1;
            ctrl.iord       = 1'b1;
            ctrl.instr_done = mem_ready;
         end
         S_RTEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RT;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_RTWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_BEQ: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_RT;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
            ctrl.instr_done    = 1'b1;
         end
         S_IEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = (opcode_q == OP_ANDI) ? ALU_AND : ALU_ADD;
         end
         S_IWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PCSRC_JUMP;
            ctrl.instr_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: 3-5 cycles per instruction when memory answers at once.
// Memory stalls hold the FSM in FETCH/MEMRD/MEMWR with the request asserted until mem_ready.
module multicycle_control
   import mc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        iord,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        mem_to_reg,
   output logic        reg_dst,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  pc_source,
   output logic [3:0]  state,
   output logic        instr_done,
   output logic        illegal_op,
   output logic [31:0] instr_count
);

   state_t      state_q, state_d;
   logic [5:0]  opcode_q, opcode_d;
   logic [31:0] instr_count_q, instr_count_d;
   logic        illegal_d;
   ctrl_t       ctrl_dec, ctrl_out;

   mc_output_decoder u_dec (
      .state     (state_q),
      .opcode_q  (opcode_q),
      .mem_ready (mem_ready),
      .ctrl      (ctrl_dec)
   );

   always_comb begin
      state_d   = state_q;
      opcode_d  = opcode_q;
      illegal_d = 1'b0;
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            opcode_d = opcode;
            case (opcode)
               OP_LW, OP_SW:     state_d = S_MEMADR;
               OP_RTYPE:         state_d = S_RTEX;
               OP_BEQ:           state_d = S_BEQ;
               OP_ADDI, OP_ANDI: state_d = S_IEX;
               OP_J:             state_d = S_JUMP;
               default: begin
                  state_d   = S_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEMADR: state_d = (opcode_q == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWR:  if (mem_ready) state_d = S_FETCH;
         S_RTEX:   state_d = S_RTWB;
         S_IEX:    state_d = S_IWB;
         default:  state_d = S_FETCH;
      endcase
   end

   assign instr_count_d = instr_count_q + {31'd0, ctrl_dec.instr_done};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_FETCH;
         opcode_q      <= '0;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         opcode_q      <= opcode_d;
         instr_count_q <= instr_count_d;
      end
   end

   // Reset forces every strobe low at once, without waiting for a clock.
   assign ctrl_out = reset ? '0 : ctrl_dec;

   assign pc_write      = ctrl_out.pc_write;
   assign pc_write_cond = ctrl_out.pc_write_cond;
   assign iord          = ctrl_out.iord;
   assign mem_read      = ctrl_out.mem_read;
   assign mem_write     = ctrl_out.mem_write;
   assign ir_write      = ctrl_out.ir_write;
   assign mem_to_reg    = ctrl_out.mem_to_reg;
   assign reg_dst       = ctrl_out.reg_dst;
   assign reg_write     = ctrl_out.reg_write;
   assign alu_src_a     = ctrl_out.alu_src_a;
   assign alu_src_b     = ctrl_out.alu_src_b;
   assign alu_op        = ctrl_out.alu_op;
   assign pc_source     = ctrl_out.pc_source;
   assign instr_done    = ctrl_out.instr_done;
   assign illegal_op    = illegal_d & ~reset;
   assign state         = state_q;
   assign instr_count   = instr_count_q;

endmodule
